// File: rtl/mem_responder.sv
// Main-memory responder: answers request/done accesses to a word array after
// a fixed number of wait cycles, with byte-enabled writes and range checking.
module mem_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned AW      = 12,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] adr,
    inout  wire  [31:0] data,
    input  logic [3:0]  byteen,
    input  logic        rwb,
    input  logic        en,
    output logic        done,
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NB = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [29:0]     adr_q;
    logic            rwb_q;
    logic [NB-1:0]   be_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            accept;
    logic            complete;
    logic            in_range;
    logic [AW-1:0]   idx;

    logic [DW-1:0]   mem [DEPTH];

    assign in_range = (adr_q[29:AW] == '0);
    assign idx      = adr_q[AW-1:0];

    // The read-data register is presented whenever the requester signals a read.
    assign data = rwb ? rdata_q : {DW{1'bz}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    accept  = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // Turnaround: a still-high en from the finished request is ignored.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture; write data only taken when the requester drives the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr_q   <= '0;
            rwb_q   <= 1'b1;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            adr_q <= adr;
            rwb_q <= rwb;
            be_q  <= byteen;
            if (!rwb) begin
                wdata_q <= data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done    <= 1'b1;
            err     <= 1'b0;
            rdata_q <= '0;
        end else begin
            done <= (state_d != BUSY);
            if (complete) begin
                err <= !in_range;
                if (rwb_q) begin
                    rdata_q <= in_range ? mem[idx] : ERRDATA;
                end
            end
        end
    end

    // Storage is not reset; an aborted access never reaches complete.
    always_ff @(posedge clk) begin
        if (complete && !rwb_q && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 and one LATENCY=1 instance,
// expected values computed by hand.
module tb_mem_responder;

    logic        clk;
    logic        reset;

    logic [29:0] adr0, adr1;
    logic [31:0] wd0, wd1;
    logic [3:0]  be0, be1;
    logic        rwb0, rwb1;
    logic        en0, en1;
    logic        done0, done1;
    logic        err0, err1;
    wire  [31:0] data0, data1;

    int nvec = 0;
    int nerr = 0;

    assign data0 = rwb0 ? 32'bz : wd0;
    assign data1 = rwb1 ? 32'bz : wd1;

    mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset), .adr(adr0), .data(data0), .byteen(be0),
        .rwb(rwb0), .en(en0), .done(done0), .err(err0)
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .adr(adr1), .data(data1), .byteen(be1),
        .rwb(rwb1), .en(en1), .done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge; returns read data, err and done-low cycles.
    task automatic req(input bit u1, input bit rw, input logic [29:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic e, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        if (u1) begin
            adr1 = a; rwb1 = rw; wd1 = wd; be1 = be; en1 = 1'b1;
        end else begin
            adr0 = a; rwb0 = rw; wd0 = wd; be0 = be; en0 = 1'b1;
        end
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (u1 ? done1 : done0) begin
                ok = 1'b1;
                break;
            end
            lat++;
        end
        if (!ok) check("timeout", 32'd0, 32'd1);
        rd = u1 ? data1 : data0;
        e  = u1 ? err1 : err0;
        if (u1) begin
            en1 = 1'b0; rwb1 = 1'b1;
        end else begin
            en0 = 1'b0; rwb0 = 1'b1;
        end
        @(negedge clk);
    endtask

    logic [31:0] rd, r1, r2;
    logic        e;
    int          lat;
    logic [7:0]  pat;

    initial begin
        reset = 1'b0;
        adr0 = '0; wd0 = '0; be0 = '0; rwb0 = 1'b1; en0 = 1'b0;
        adr1 = '0; wd1 = '0; be1 = '0; rwb1 = 1'b1; en1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", 32'(done0), 32'd1);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_rdata", data0, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Full write then read back
        req(1'b0, 1'b0, 30'h4AD, 32'hDDCCBBAA, 4'b1111, rd, e, lat);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_err", 32'(e), 32'd0);
        req(1'b0, 1'b1, 30'h4AD, 32'h0, 4'b0000, rd, e, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", rd, 32'hDDCCBBAA);
        check("rd_err", 32'(e), 32'd0);

        // Byte merge
        req(1'b0, 1'b0, 30'h10, 32'h11223344, 4'b1111, rd, e, lat);
        req(1'b0, 1'b0, 30'h10, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        req(1'b0, 1'b1, 30'h10, 32'h0, 4'b0000, rd, e, lat);
        check("merge_data", rd, 32'h11BB33DD);
        req(1'b0, 1'b0, 30'h10, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        req(1'b0, 1'b1, 30'h10, 32'h0, 4'b0000, rd, e, lat);
        check("be0_nochange", rd, 32'h11BB33DD);

        // Out of range
        req(1'b0, 1'b0, 30'h0, 32'h0BADF00D, 4'b1111, rd, e, lat);
        req(1'b0, 1'b1, 30'h1000, 32'h0, 4'b0000, rd, e, lat);
        check("oor_data", rd, 32'hDEADBEEF);
        check("oor_err", 32'(e), 32'd1);
        req(1'b0, 1'b1, 30'h4AD, 32'h0, 4'b0000, rd, e, lat);
        check("oor_clr_err", 32'(e), 32'd0);
        req(1'b0, 1'b0, 30'h1000, 32'h12345678, 4'b1111, rd, e, lat);
        check("oor_wr_err", 32'(e), 32'd1);
        req(1'b0, 1'b1, 30'h0, 32'h0, 4'b0000, rd, e, lat);
        check("oor_wr_arr0", rd, 32'h0BADF00D);

        // Turnaround with en held across two reads
        rwb0 = 1'b1; adr0 = 30'h4AD; en0 = 1'b1; pat = '0;
        for (int k = 0; k < 8; k++) begin
            pat = {pat[6:0], done0};
            if (k == 3) begin
                r1 = data0; adr0 = 30'h10;
            end
            if (k == 7) begin
                r2 = data0; en0 = 1'b0;
            end
            @(negedge clk);
        end
        check("turn_pattern", 32'(pat), 32'h99);
        check("turn_rd1", r1, 32'hDDCCBBAA);
        check("turn_rd2", r2, 32'h11BB33DD);

        // Reset during a pending write, with err previously set
        req(1'b0, 1'b0, 30'h20, 32'h0, 4'b1111, rd, e, lat);
        req(1'b0, 1'b1, 30'h1000, 32'h0, 4'b0000, rd, e, lat);
        adr0 = 30'h20; rwb0 = 1'b0; wd0 = 32'hFFFFFFFF; be0 = 4'b1111; en0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(done0), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_done", 32'(done0), 32'd1);
        check("mid_rst_err", 32'(err0), 32'd0);
        en0 = 1'b0; rwb0 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        req(1'b0, 1'b1, 30'h20, 32'h0, 4'b0000, rd, e, lat);
        check("mid_rd20", rd, 32'h0);

        // LATENCY=1 instance
        req(1'b1, 1'b0, 30'h0, 32'h12345678, 4'b1111, rd, e, lat);
        check("l1_wr_lat", 32'(lat), 32'd1);
        req(1'b1, 1'b0, 30'hAD, 32'hCAFEF00D, 4'b1111, rd, e, lat);
        req(1'b1, 1'b1, 30'h0, 32'h0, 4'b0000, rd, e, lat);
        check("l1_rd0_lat", 32'(lat), 32'd1);
        check("l1_rd0", rd, 32'h12345678);
        req(1'b1, 1'b1, 30'hAD, 32'h0, 4'b0000, rd, e, lat);
        check("l1_rdad_lat", 32'(lat), 32'd1);
        check("l1_rdad", rd, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
